sh_chain_reader: RTL and testbench

//  Reads back a sh_dff shift chain: enables shifting, samples the chain's serial tail bit and packs
//  the bits into WORD_W-bit words. Words leave on a valid/ready stream. Sits beside the fabric

---
 rtl/sh_chain_reader_pkg.sv | 15 +
 rtl/sh_chain_word_buf.sv | 27 ++
 rtl/sh_chain_reader.sv | 109 ++++++++++
 tb/tb_sh_chain_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sh_chain_reader_pkg.sv
// Shared types and helpers for the shift-chain readback path.
package qlf_k6n10f_shchain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int unsigned words_for(input int unsigned len, input int unsigned w);
    return (len + w - 1) / w;
  endfunction

endpackage

// File: rtl/sh_chain_word_buf.sv
// One-deep valid/ready output register for assembled readback words.
module sh_chain_word_buf #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              C,
  input  logic              R,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid
);

  // A load wins over a same-edge transfer so back-to-back words keep rd_valid high.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (load) begin
      rd_data  <= load_data;
      rd_valid <= 1'b1;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sh_chain_reader.sv
// Reads back a sh_dff shift chain through its serial tail and packs the bits into words.
module sh_chain_reader
  import qlf_k6n10f_shchain_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic              C,
  input  logic              R,
  input  logic              start,
  input  logic              sdi,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready
);

  localparam int unsigned NW = words_for(CHAIN_LEN, WORD_W);
  localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned XW = $clog2(NW + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CHAIN_LEN - 1);
  localparam logic [BW-1:0] POS_LAST  = BW'(WORD_W - 1);
  localparam logic [XW-1:0] WORD_LAST = XW'(NW - 1);

  state_t            state;
  logic [CW-1:0]     bit_cnt;
  logic [BW-1:0]     bidx;
  logic [XW-1:0]     xfer_cnt;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] asm_next;
  logic              chain_end;
  logic              word_end;
  logic              load;
  logic              xfer;
  int unsigned       pos;

  assign chain_end = (bit_cnt == BIT_LAST);
  assign word_end  = (bidx == POS_LAST) || chain_end;
  // Stall only when the completing bit has nowhere to go this edge.
  assign shift_en  = (state == SHIFT) && !(word_end && rd_valid && !rd_ready);
  assign load      = shift_en && word_end;
  assign xfer      = rd_valid && rd_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    pos      = (LSB_FIRST != 0) ? 32'(bidx) : (WORD_W - 1) - 32'(bidx);
    asm_next = asm_q;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      if (i == pos) asm_next[i] = sdi;
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bidx     <= '0;
      xfer_cnt <= '0;
      asm_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            bidx     <= '0;
            xfer_cnt <= '0;
            asm_q    <= '0;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            bit_cnt <= bit_cnt + 1'b1;
            bidx    <= word_end ? '0 : bidx + 1'b1;
            asm_q   <= word_end ? '0 : asm_next;
            if (chain_end) state <= DRAIN;
          end
          if (xfer) xfer_cnt <= xfer_cnt + 1'b1;
        end
        DRAIN: begin
          if (xfer) begin
            xfer_cnt <= xfer_cnt + 1'b1;
            if (xfer_cnt == WORD_LAST) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sh_chain_word_buf #(
    .WORD_W(WORD_W)
  ) u_buf (
    .C         (C),
    .R         (R),
    .load      (load),
    .load_data (asm_next),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

endmodule

// File: tb/tb_sh_chain_reader.sv
// Directed bench for sh_chain_reader across several chain/word geometries.
module tb_sh_chain_reader;

  logic C, R;

  logic startA, rdyA, sdiA, shA, busyA, doneA, vA;
  logic [7:0] dA;
  logic startB, rdyB, sdiB, shB, busyB, doneB, vB;
  logic [7:0] dB;
  logic sdiM, shM, busyM, doneM, vM;
  logic [7:0] dM;
  logic startD, rdyD, sdiD, shD, busyD, doneD, vD;
  logic [0:0] dD;

  logic [15:0] chA, pat16;
  logic [11:0] chB, chM, pat12;
  logic ldA, ldB;

  int nerr, nchk;
  int nsh, first_se, last_se, se15, done_k, nw, busy_gap, busy_after, done_after;
  logic [7:0] w0, w1, stall_d;
  int nshB, done_kB, nb, nm, vcount;
  logic [7:0] wb0, wb1, wm0, wm1;

  sh_chain_reader #(.CHAIN_LEN(16), .WORD_W(8), .LSB_FIRST(1)) u_a (
    .C(C), .R(R), .start(startA), .sdi(sdiA), .shift_en(shA), .busy(busyA),
    .done(doneA), .rd_data(dA), .rd_valid(vA), .rd_ready(rdyA));

  sh_chain_reader #(.CHAIN_LEN(12), .WORD_W(8), .LSB_FIRST(1)) u_b (
    .C(C), .R(R), .start(startB), .sdi(sdiB), .shift_en(shB), .busy(busyB),
    .done(doneB), .rd_data(dB), .rd_valid(vB), .rd_ready(rdyB));

  sh_chain_reader #(.CHAIN_LEN(12), .WORD_W(8), .LSB_FIRST(0)) u_m (
    .C(C), .R(R), .start(startB), .sdi(sdiM), .shift_en(shM), .busy(busyM),
    .done(doneM), .rd_data(dM), .rd_valid(vM), .rd_ready(rdyB));

  sh_chain_reader #(.CHAIN_LEN(1), .WORD_W(1), .LSB_FIRST(1)) u_d (
    .C(C), .R(R), .start(startD), .sdi(sdiD), .shift_en(shD), .busy(busyD),
    .done(doneD), .rd_data(dD), .rd_valid(vD), .rd_ready(rdyD));

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  // Chain models: stage nearest the tail (bit 0) is read first.
  always @(posedge C) begin
    if (ldA) chA <= pat16;
    else if (shA) chA <= {1'b0, chA[15:1]};
    if (ldB) begin
      chB <= pat12;
      chM <= pat12;
    end else begin
      if (shB) chB <= {1'b0, chB[11:1]};
      if (shM) chM <= {1'b0, chM[11:1]};
    end
  end
  assign sdiA = chA[0];
  assign sdiB = chB[0];
  assign sdiM = chM[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic [15:0] p);
    @(negedge C);
    pat16 = p;
    ldA = 1'b1;
    @(negedge C);
    ldA = 1'b0;
  endtask

  task automatic run_a(input int ready_at, input int restart_at);
    nsh = 0; first_se = -1; last_se = -1; se15 = -1; done_k = -1;
    nw = 0; busy_gap = 0; w0 = '0; w1 = '0; stall_d = '0;
    @(negedge C);
    startA = 1'b1;
    rdyA = (ready_at == 0);
    @(negedge C);
    for (int k = 0; k < 60; k++) begin
      startA = (k == restart_at);
      rdyA = (k >= ready_at);
      #1;
      if (shA) begin
        nsh++;
        if (first_se < 0) first_se = k;
        last_se = k;
      end
      if (k == 15) se15 = int'(shA);
      if (k == 20) stall_d = dA;
      if (vA && rdyA) begin
        if (nw == 0) w0 = dA;
        else if (nw == 1) w1 = dA;
        nw++;
      end
      if (!busyA) busy_gap++;
      if (doneA) begin
        done_k = k;
        break;
      end
      @(negedge C);
    end
    startA = 1'b0;
    @(negedge C);
    #1;
    busy_after = int'(busyA);
    done_after = int'(doneA);
  endtask

  task automatic run_bc(input logic [11:0] p);
    nshB = 0; done_kB = -1; nb = 0; nm = 0;
    wb0 = '0; wb1 = '0; wm0 = '0; wm1 = '0;
    @(negedge C);
    pat12 = p;
    ldB = 1'b1;
    @(negedge C);
    ldB = 1'b0;
    startB = 1'b1;
    rdyB = 1'b1;
    @(negedge C);
    startB = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (shB) nshB++;
      if (vB) begin
        if (nb == 0) wb0 = dB; else wb1 = dB;
        nb++;
      end
      if (vM) begin
        if (nm == 0) wm0 = dM; else wm1 = dM;
        nm++;
      end
      if (doneB) begin
        done_kB = k;
        break;
      end
      @(negedge C);
    end
  endtask

  initial begin
    nerr = 0; nchk = 0;
    R = 1'b0;
    startA = 1'b0; rdyA = 1'b0; startB = 1'b0; rdyB = 1'b0;
    startD = 1'b0; rdyD = 1'b0; sdiD = 1'b1;
    ldA = 1'b0; ldB = 1'b0; pat16 = '0; pat12 = '0;
    #1;
    chk("rst_shift_en", 32'(shA), 32'd0);
    chk("rst_busy",     32'(busyA), 32'd0);
    chk("rst_done",     32'(doneA), 32'd0);
    chk("rst_valid",    32'(vA), 32'd0);
    chk("rst_data",     32'(dA), 32'd0);
    @(negedge C);
    R = 1'b1;

    // 1: contiguous readback with consumer always ready
    load_a(16'h3CA5);
    run_a(0, -1);
    chk("t1_shifts",   32'(nsh), 32'd16);
    chk("t1_first",    32'(first_se), 32'd0);
    chk("t1_last",     32'(last_se), 32'd15);
    chk("t1_nwords",   32'(nw), 32'd2);
    chk("t1_w0",       32'(w0), 32'hA5);
    chk("t1_w1",       32'(w1), 32'h3C);
    chk("t1_done_k",   32'(done_k), 32'd17);
    chk("t1_busy_gap", 32'(busy_gap), 32'd0);
    chk("t1_idle",     32'(busy_after), 32'd0);
    chk("t1_done_1cy", 32'(done_after), 32'd0);

    // 2: back-pressure until cycle 30
    load_a(16'h3CA5);
    run_a(30, -1);
    chk("t2_stall_bit15", 32'(se15), 32'd0);
    chk("t2_hold_data",   32'(stall_d), 32'hA5);
    chk("t2_shifts",      32'(nsh), 32'd16);
    chk("t2_last",        32'(last_se), 32'd30);
    chk("t2_nwords",      32'(nw), 32'd2);
    chk("t2_w0",          32'(w0), 32'hA5);
    chk("t2_w1",          32'(w1), 32'h3C);
    chk("t2_done_k",      32'(done_k), 32'd32);

    // 3: partial final word, both bit orders
    run_bc(12'hFFF);
    chk("t3_shifts", 32'(nshB), 32'd12);
    chk("t3_nb",     32'(nb), 32'd2);
    chk("t3_wb0",    32'(wb0), 32'hFF);
    chk("t3_wb1",    32'(wb1), 32'h0F);
    chk("t3_nm",     32'(nm), 32'd2);
    chk("t3_wm0",    32'(wm0), 32'hFF);
    chk("t3_wm1",    32'(wm1), 32'hF0);
    chk("t3_done_k", 32'(done_kB), 32'd13);
    run_bc(12'h5A3);
    chk("t3p_wb0", 32'(wb0), 32'hA3);
    chk("t3p_wb1", 32'(wb1), 32'h05);
    chk("t3p_wm0", 32'(wm0), 32'hC5);
    chk("t3p_wm1", 32'(wm1), 32'hA0);

    // 4: second start while shifting is ignored
    load_a(16'h3CA5);
    run_a(0, 5);
    chk("t4_shifts",   32'(nsh), 32'd16);
    chk("t4_nwords",   32'(nw), 32'd2);
    chk("t4_w1",       32'(w1), 32'h3C);
    chk("t4_busy_gap", 32'(busy_gap), 32'd0);
    chk("t4_done_k",   32'(done_k), 32'd17);

    // 5: asynchronous reset mid-readback, then a clean readback
    load_a(16'h3CA5);
    @(negedge C);
    startA = 1'b1;
    rdyA = 1'b0;
    @(negedge C);
    startA = 1'b0;
    repeat (13) @(negedge C);
    #1;
    chk("t5_pre_shift", 32'(shA), 32'd1);
    chk("t5_pre_valid", 32'(vA), 32'd1);
    chk("t5_pre_busy",  32'(busyA), 32'd1);
    #2;
    R = 1'b0;
    #1;
    chk("t5_rst_shift", 32'(shA), 32'd0);
    chk("t5_rst_busy",  32'(busyA), 32'd0);
    chk("t5_rst_valid", 32'(vA), 32'd0);
    chk("t5_rst_data",  32'(dA), 32'd0);
    @(negedge C);
    R = 1'b1;
    rdyA = 1'b1;
    vcount = 0;
    repeat (5) begin
      @(negedge C);
      #1;
      if (vA || busyA) vcount++;
    end
    chk("t5_no_emit", 32'(vcount), 32'd0);
    load_a(16'h3CA5);
    run_a(0, -1);
    chk("t5_shifts",  32'(nsh), 32'd16);
    chk("t5_w0",      32'(w0), 32'hA5);
    chk("t5_w1",      32'(w1), 32'h3C);
    chk("t5_done_k",  32'(done_k), 32'd17);

    // 6: single-stage chain, single-bit words
    @(negedge C);
    startD = 1'b1;
    rdyD = 1'b1;
    @(negedge C);
    startD = 1'b0;
    nsh = 0; nw = 0; done_k = -1; w0 = '0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (shD) nsh++;
      if (vD) begin
        nw++;
        w0 = 8'(dD);
      end
      if (doneD) begin
        done_k = k;
        break;
      end
      @(negedge C);
    end
    chk("t6_shifts", 32'(nsh), 32'd1);
    chk("t6_nwords", 32'(nw), 32'd1);
    chk("t6_word",   32'(w0), 32'd1);
    chk("t6_done_k", 32'(done_k), 32'd2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
